// File: rtl/soda_pkg.sv
// Shared definitions for the soda dispenser front end: coin codes,
// coin_detect FSM state encoding and the default coin-value width.
package soda_pkg;

  localparam int VAL_W_DEFAULT = 8;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DB_ON,
    PEND,
    EMIT,
    REJ,
    WAIT_REL,
    DB_OFF
  } state_e;

  function automatic logic coin_valid(input logic [1:0] code);
    return code != COIN_NONE;
  endfunction

endpackage

// File: rtl/coin_detect_if.sv
// Coin acceptor / controller signal bundle around coin_detect.
// master = acceptor + controller side, slave = coin_detect.
interface coin_detect_if #(
  parameter int VAL_W = soda_pkg::VAL_W_DEFAULT
);
  logic             coin_sense;
  logic [1:0]       coin_code;
  logic             inhibit;
  logic             c;
  logic [VAL_W-1:0] a;
  logic             reject;
  logic             busy;

  modport master (
    output coin_sense, coin_code, inhibit,
    input  c, a, reject, busy
  );

  modport slave (
    input  coin_sense, coin_code, inhibit,
    output c, a, reject, busy
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear on
// asynchronous active-low reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so the second stage takes the first
  // stage's previous value, forming a real two-flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/coin_detect.sv
// Coin front end: synchronizes and debounces the acceptor inputs and turns
// each accepted coin into one c pulse (value on a) or one reject pulse.
module coin_detect
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int VAL_W           = VAL_W_DEFAULT,
  parameter int NICKEL_VAL      = 5,
  parameter int DIME_VAL        = 10,
  parameter int QUARTER_VAL     = 25
) (
  input  logic          clk,
  input  logic          rst,
  coin_detect_if.slave  bus
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s_sense;
  logic [1:0]       s_code;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       code_q,  code_d;
  logic [VAL_W-1:0] a_q,     a_d;

  function automatic logic [VAL_W-1:0] decode(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  return VAL_W'(NICKEL_VAL);
      COIN_DIME:    return VAL_W'(DIME_VAL);
      COIN_QUARTER: return VAL_W'(QUARTER_VAL);
      default:      return '0;
    endcase
  endfunction

  sync2 #(.WIDTH(1)) u_sync_sense (
    .clk (clk),
    .rst (rst),
    .d_i (bus.coin_sense),
    .q_o (s_sense)
  );

  sync2 #(.WIDTH(2)) u_sync_code (
    .clk (clk),
    .rst (rst),
    .d_i (bus.coin_code),
    .q_o (s_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= COIN_NONE;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      a_q     <= a_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    a_d     = a_q;

    case (state_q)
      IDLE: begin
        if (s_sense) begin
          state_d = DB_ON;
          cnt_d   = '0;
        end
      end

      DB_ON: begin
        if (!s_sense) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          code_d = s_code;
          if (!coin_valid(s_code)) begin
            state_d = REJ;
          end else if (bus.inhibit) begin
            state_d = PEND;
          end else begin
            state_d = EMIT;
            a_d     = decode(s_code);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The coin is already accepted here; removal must not lose it.
      PEND: begin
        if (!bus.inhibit) begin
          state_d = EMIT;
          a_d     = decode(code_q);
        end
      end

      EMIT: state_d = WAIT_REL;

      REJ:  state_d = WAIT_REL;

      WAIT_REL: begin
        if (!s_sense) begin
          state_d = DB_OFF;
          cnt_d   = '0;
        end
      end

      DB_OFF: begin
        if (s_sense) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pulses decode straight from state so reset clears them without a clock.
  assign bus.c      = (state_q == EMIT);
  assign bus.reject = (state_q == REJ);
  assign bus.busy   = (state_q != IDLE);
  assign bus.a      = a_q;

endmodule

// File: doc/coin_detect.md
Name: coin_detect

Overview:
- Front-end stage directly upstream of the soda dispenser controller.
- Takes the raw coin-acceptor sense line and 2-bit denomination code, then synchronizes and debounces them.
- Converts each accepted coin into exactly one single-cycle `c` pulse, with the coin value `a` held stable for the controller's add step.
- Invalid coins are rejected. Coins that arrive while the dispenser is busy are held and released afterwards.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized-stable cycles required on both the assert and release edges (must be >= 1).
- VAL_W, 8, width of the coin value output.
- NICKEL_VAL, 5, value emitted for code 2'b01.
- DIME_VAL, 10, value emitted for code 2'b10.
- QUARTER_VAL, 25, value emitted for code 2'b11.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- coin_sense  in  1  raw acceptor sense line, asynchronous, glitchy; high while a coin is in the slot.
- coin_code  in  2  raw denomination code, valid while coin_sense is high; 00 = unrecognised.
- inhibit  in  1  high while the dispenser is dispensing (driven from the controller's dispense output).
- c  out  1  one-cycle "coin accepted" pulse to the controller.
- a  out  VAL_W  value of the most recently accepted coin; stable until the next c.
- reject  out  1  one-cycle pulse for an unrecognised coin.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, c=0, reject=0, a=0, busy=0, synchronizer flops=0, debounce counter=0.
- Input capture: coin_sense and coin_code each pass through a 2-flop synchronizer. All logic below uses only the synchronized versions (s_sense, s_code).
- FSM states:
  - IDLE, DB_ON, PEND, EMIT, REJ, WAIT_REL, DB_OFF.
- Transitions:
  - IDLE: s_sense=1 -> DB_ON, counter cleared.
  - DB_ON: s_sense=0 -> IDLE (glitch discarded, no output). Otherwise the counter increments. At counter=DEBOUNCE_CYCLES-1, latch s_code into code_q, then:
    - code_q=00 -> REJ.
    - else inhibit=1 -> PEND.
    - else -> EMIT.
  - PEND: hold code_q and ignore s_sense. Leave for EMIT in the first cycle inhibit=0.
  - EMIT: c=1 for exactly this cycle. `a` is loaded with the decoded value on the edge entering EMIT, so it is valid in the same cycle as c. Next state is WAIT_REL.
  - REJ: reject=1 for exactly this cycle; `a` is unchanged. Next state is WAIT_REL.
  - WAIT_REL: s_sense=0 -> DB_OFF, counter cleared.
  - DB_OFF: s_sense=1 -> WAIT_REL (release glitch). At counter=DEBOUNCE_CYCLES-1 with s_sense=0 -> IDLE.
- Latency: if coin_sense rises before edge 0 and stays high, c (or reject) is high in the cycle after edge DEBOUNCE_CYCLES+2, provided inhibit=0.
- Decoding: 01 -> NICKEL_VAL, 10 -> DIME_VAL, 11 -> QUARTER_VAL, zero-extended/truncated to VAL_W.
- Pulse guarantees:
  - At most one c or reject per physical insertion.
  - c and reject are never high together.
  - Two c pulses are always separated by at least 2*DEBOUNCE_CYCLES cycles.
- `a` holds its value across c deassertion; the controller samples it during its add cycle, one cycle after c.
- Inhibit only gates the EMIT transition. A coin that is still inserted during inhibit waits in PEND; it is never dropped or double-counted.
- Coin removed while in PEND: the coin was already accepted, so it is still emitted. WAIT_REL then sees s_sense=0 and proceeds normally.
- Reset mid-operation: any pending or debouncing coin is discarded and no pulse is produced.

Decomposition:
- Shared package soda_pkg:
  - coin code localparams (COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10, COIN_QUARTER=2'b11).
  - FSM state encodings.
  - VAL_W default.
- One sub-module, sync2: a 2-flop synchronizer parameterised by width, async active-low reset. Instantiated for sense (width 1) and code (width 2).

Test Plan:
- Clean dime: coin_sense=1, coin_code=10 held for 20 cycles with DEBOUNCE_CYCLES=4 -> exactly one c pulse, 7 cycles after the first sampled high; a=10 from the c cycle onward; reject stays 0.
- Glitch: coin_sense high for 2 cycles then low -> no c, no reject, back to IDLE (busy=0) within 5 cycles.
- Bounce: quarter inserted with 3 on/off chatter edges on both insertion and release -> exactly one c with a=25; the next coin is accepted normally.
- Unrecognised: coin_code=00 with a clean insert -> one reject pulse, c=0, a keeps its previous value (e.g. 25).
- Inhibit: nickel inserted while inhibit=1 for 30 cycles -> no c while inhibit is high; c pulse with a=5 in the first cycle after inhibit falls.
- Async reset: assert rst=0 while in DB_ON -> all outputs 0 immediately, with no clock edge needed; after release, no pulse is produced for the aborted coin.
